mem_ctrl: RTL

- Load/store front end that sits directly upstream of the processor's 16-bit word-addressed data memory.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Converts each request into the memory's word address, byte-lane and enable controls, and honours the memory's wait signal.
- Returns load data byte-extracted and zero- or sign-extended, with an error flag for bad accesses.

---
 rtl/mem_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Load/store front end for a 16-bit word-addressed data memory: byte-address
// translation, lane control, wait handling and load extension. Build option: MEM_CTRL_MISALIGN_CHECK_EN.
module mem_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_write_enable,
    output logic        mem_byte_enable,
    output logic        mem_byte_select,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_wait,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        lat_write, lat_byte, lat_signed;
    logic [15:0] lat_addr, lat_wdata;
    logic        addr_bad;
    logic [7:0]  load_byte;

    always_comb begin
        addr_bad = (32'(req_addr[15:1]) >= MEM_WORDS);
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        if (!req_byte && req_addr[0]) addr_bad = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write  <= 1'b0;
            lat_byte   <= 1'b0;
            lat_signed <= 1'b0;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
        end else if (state == IDLE && req_valid) begin
            lat_write  <= req_write;
            lat_byte   <= req_byte;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    always_comb begin
        state_nxt        = state;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = 16'h0000;
        resp_err         = 1'b0;
        mem_en           = 1'b0;
        mem_write_enable = 1'b0;
        mem_byte_enable  = 1'b0;
        mem_byte_select  = 1'b0;
        mem_addr         = 16'h0000;
        mem_data_in      = 16'h0000;
        load_byte        = lat_addr[0] ? mem_data_out[15:8] : mem_data_out[7:0];
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = addr_bad ? ERR : ACCESS;
            end
            ACCESS: begin
                // Outputs come only from the latched request, so they hold steady while stalled.
                mem_en           = 1'b1;
                mem_write_enable = lat_write;
                mem_byte_enable  = lat_byte;
                mem_byte_select  = lat_addr[0];
                mem_addr         = {1'b0, lat_addr[15:1]};
                mem_data_in      = lat_wdata;
                if (!mem_wait) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (!lat_write) begin
                    if (lat_byte) resp_rdata = {{8{lat_signed & load_byte[7]}}, load_byte};
                    else          resp_rdata = mem_data_out;
                end
                state_nxt = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule
